// File: rtl/i2c_arb_if.sv
// Request/response and I2C-master handshake bundle for i2c_arb.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding logic (requesters plus the I2C master engine).
interface i2c_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_val_i;
  logic [7*N_REQ-1:0] req_daddr_i;
  logic [8*N_REQ-1:0] req_addr_i;
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_wen_i;
  logic [N_REQ-1:0]   req_rdy_o;
  logic [N_REQ-1:0]   rsp_val_o;
  logic               rsp_err_o;
  logic [7:0]         rsp_data_o;
  logic [N_REQ-1:0]   rsp_rdy_i;
  logic               m_val_o;
  logic [6:0]         m_daddr_o;
  logic [7:0]         m_addr_o;
  logic [7:0]         m_data_o;
  logic               m_wen_o;
  logic               m_rdy_i;
  logic               m_val_i;
  logic               m_err_i;
  logic [7:0]         m_data_i;
  logic               m_rdy_o;

  modport slave (
    input  req_val_i, req_daddr_i, req_addr_i, req_data_i, req_wen_i, rsp_rdy_i,
           m_rdy_i, m_val_i, m_err_i, m_data_i,
    output req_rdy_o, rsp_val_o, rsp_err_o, rsp_data_o,
           m_val_o, m_daddr_o, m_addr_o, m_data_o, m_wen_o, m_rdy_o
  );

  modport master (
    output req_val_i, req_daddr_i, req_addr_i, req_data_i, req_wen_i, rsp_rdy_i,
           m_rdy_i, m_val_i, m_err_i, m_data_i,
    input  req_rdy_o, rsp_val_o, rsp_err_o, rsp_data_o,
           m_val_o, m_daddr_o, m_addr_o, m_data_o, m_wen_o, m_rdy_o
  );
endinterface

// File: rtl/i2c_arb.sv
// Round-robin arbiter and NACK retry sequencer in front of a single I2C master.
// One transaction is outstanding at a time; the captured request fields are
// replayed on each retry so the requester is handshaked exactly once.
module i2c_arb #(
  parameter int N_REQ   = 4,
  parameter int RETRIES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  i2c_arb_if.slave    bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [2:0]        retry_q, retry_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wen_q, wen_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        rsp_data_q, rsp_data_d;

  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [IW-1:0]     idx_s;
  logic [N_REQ-1:0]  req_rdy_s;
  logic              issue_s;

  // Pick the first valid requester after the last one served (wrapping).
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s = IW'((int'(last_q) + i) % N_REQ);
      if (!found_s && bus.req_val_i[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the sequencer and its held transaction fields.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    retry_d    = retry_q;
    daddr_d    = daddr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wen_d      = wen_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    req_rdy_s  = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          req_rdy_s[pick_s] = 1'b1;
          grant_d = pick_s;
          retry_d = 3'd0;
          daddr_d = bus.req_daddr_i[int'(pick_s)*7 +: 7];
          addr_d  = bus.req_addr_i[int'(pick_s)*8 +: 8];
          data_d  = bus.req_data_i[int'(pick_s)*8 +: 8];
          wen_d   = bus.req_wen_i[pick_s];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.m_rdy_i) begin
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (bus.m_val_i) begin
          rsp_err_d  = bus.m_err_i;
          rsp_data_d = bus.m_data_i;
          // A NACK with retries left replays the held fields.
          if (bus.m_err_i && (retry_q < 3'(RETRIES))) begin
            retry_d = retry_q + 3'd1;
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_rdy_i[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and holding registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_q     <= IW'(N_REQ - 1);
      grant_q    <= '0;
      retry_q    <= 3'd0;
      daddr_q    <= 7'd0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      wen_q      <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      retry_q    <= retry_d;
      daddr_q    <= daddr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Master request fields are driven only while a request is being offered.
  assign issue_s       = (state_q == ISSUE);
  assign bus.m_val_o   = issue_s;
  assign bus.m_daddr_o = issue_s ? daddr_q : 7'd0;
  assign bus.m_addr_o  = issue_s ? addr_q  : 8'd0;
  assign bus.m_data_o  = issue_s ? data_q  : 8'd0;
  assign bus.m_wen_o   = issue_s ? wen_q   : 1'b0;
  assign bus.m_rdy_o   = (state_q == WAIT);
  assign bus.rsp_val_o = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign bus.rsp_err_o = rsp_err_q;
  assign bus.rsp_data_o = rsp_data_q;
  assign bus.req_rdy_o = req_rdy_s;
endmodule

// File: tb/tb_i2c_arb.sv
// Directed self-checking bench for i2c_arb (N_REQ=4, RETRIES=2).
module tb_i2c_arb;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   total = 0;
  int   bad   = 0;

  i2c_arb_if #(.N_REQ(4)) bus ();

  i2c_arb #(.N_REQ(4), .RETRIES(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic post(input int k, input logic [6:0] da, input logic [7:0] ra,
                      input logic [7:0] wd, input logic w);
    bus.req_val_i[k]           = 1'b1;
    bus.req_daddr_i[7*k +: 7]  = da;
    bus.req_addr_i[8*k +: 8]   = ra;
    bus.req_data_i[8*k +: 8]   = wd;
    bus.req_wen_i[k]           = w;
  endtask

  // Accept requester g, play the master (NACK the first nack_n attempts),
  // then check the response and hand it back.
  task automatic serve(input int g, input logic [6:0] da, input logic [7:0] ra,
                       input logic [7:0] wd, input logic w, input int nack_n,
                       input logic [7:0] rd, input int exp_att, input logic exp_err,
                       input bit keep);
    int         att;
    bit         got;
    logic [3:0] oh;
    att = 0;
    got = 1'b0;
    oh  = 4'b0001 << g;
    @(negedge clk_i);
    check_val("accept", 32'(bus.req_rdy_o), 32'(oh));
    @(posedge clk_i); #1;
    if (!keep) bus.req_val_i[g] = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk_i);
      if (bus.rsp_val_o != 4'b0000) begin
        got = 1'b1;
      end else if (bus.m_val_o) begin
        att++;
        check_val("m_daddr", 32'(bus.m_daddr_o), 32'(da));
        check_val("m_addr", 32'(bus.m_addr_o), 32'(ra));
        check_val("m_data", 32'(bus.m_data_o), 32'(wd));
        check_val("m_wen", 32'(bus.m_wen_o), 32'(w));
        check_val("holdoff", 32'(bus.req_rdy_o), 32'(0));
        bus.m_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        bus.m_rdy_i  = 1'b0;
        bus.m_val_i  = 1'b1;
        bus.m_err_i  = (att <= nack_n);
        bus.m_data_i = rd;
        @(negedge clk_i);
        check_val("wait_out", 32'({bus.m_rdy_o, bus.m_val_o}), 32'(2'b10));
        @(posedge clk_i); #1;
        bus.m_val_i  = 1'b0;
        bus.m_err_i  = 1'b0;
        bus.m_data_i = 8'h00;
      end else begin
        check_val("stall", 32'(bus.m_val_o), 32'(1));
      end
    end
    check_val("attempts", 32'(att), 32'(exp_att));
    check_val("rsp_val", 32'(bus.rsp_val_o), 32'(oh));
    check_val("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
    if (!w) check_val("rsp_data", 32'(bus.rsp_data_o), 32'(rd));
    bus.rsp_rdy_i = ~oh;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_val("rsp_hold", 32'(bus.rsp_val_o), 32'(oh));
    bus.rsp_rdy_i = oh;
    @(posedge clk_i); #1;
    bus.rsp_rdy_i = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni          = 1'b0;
    bus.req_val_i   = '0;
    bus.req_daddr_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_wen_i   = '0;
    bus.rsp_rdy_i   = '0;
    bus.m_rdy_i     = 1'b0;
    bus.m_val_i     = 1'b0;
    bus.m_err_i     = 1'b0;
    bus.m_data_i    = 8'h00;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_req_rdy", 32'(bus.req_rdy_o), 32'(0));
    check_val("rst_rsp_val", 32'(bus.rsp_val_o), 32'(0));
    check_val("rst_m_val", 32'(bus.m_val_o), 32'(0));
    check_val("rst_m_rdy", 32'(bus.m_rdy_o), 32'(0));
    check_val("rst_m_fields", 32'({bus.m_daddr_o, bus.m_addr_o, bus.m_data_o, bus.m_wen_o}), 32'(0));
    check_val("rst_rsp_err", 32'(bus.rsp_err_o), 32'(0));
    check_val("rst_rsp_data", 32'(bus.rsp_data_o), 32'(0));

    // All four requesters valid from reset: grants rotate 0,1,2,3,0,1.
    for (int k = 0; k < 4; k++) post(k, 7'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k), 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    serve(0, 7'h10, 8'h20, 8'h30, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    serve(1, 7'h11, 8'h21, 8'h31, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    serve(2, 7'h12, 8'h22, 8'h32, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    serve(3, 7'h13, 8'h23, 8'h33, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    serve(0, 7'h10, 8'h20, 8'h30, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    serve(1, 7'h11, 8'h21, 8'h31, 1'b1, 0, 8'h00, 1, 1'b0, 1'b1);
    bus.req_val_i = 4'b0000;

    // Single write from requester 1.
    post(1, 7'h50, 8'h10, 8'hA5, 1'b1);
    serve(1, 7'h50, 8'h10, 8'hA5, 1'b1, 0, 8'h00, 1, 1'b0, 1'b0);

    // Read from requester 2 returning 0x3C.
    post(2, 7'h21, 8'h05, 8'h00, 1'b0);
    serve(2, 7'h21, 8'h05, 8'h00, 1'b0, 0, 8'h3C, 1, 1'b0, 1'b0);

    // One NACK then ACK: two attempts, clean status.
    post(3, 7'h48, 8'h02, 8'h11, 1'b1);
    serve(3, 7'h48, 8'h02, 8'h11, 1'b1, 1, 8'h00, 2, 1'b0, 1'b0);

    // Always NACK: three attempts, error reported.
    post(0, 7'h1A, 8'h7F, 8'hEE, 1'b0);
    serve(0, 7'h1A, 8'h7F, 8'hEE, 1'b0, 99, 8'h55, 3, 1'b1, 1'b0);

    // Lone requester 0 is granted again back-to-back.
    post(0, 7'h33, 8'h44, 8'h55, 1'b1);
    serve(0, 7'h33, 8'h44, 8'h55, 1'b1, 0, 8'h00, 1, 1'b0, 1'b0);

    // Reset while waiting on the master.
    post(2, 7'h66, 8'h77, 8'h88, 1'b1);
    @(negedge clk_i);
    check_val("rw_accept", 32'(bus.req_rdy_o), 32'(4'b0100));
    @(posedge clk_i); #1;
    bus.req_val_i = 4'b0000;
    @(negedge clk_i);
    check_val("rw_m_val", 32'(bus.m_val_o), 32'(1));
    bus.m_rdy_i = 1'b1;
    @(posedge clk_i); #1;
    bus.m_rdy_i  = 1'b0;
    bus.m_val_i  = 1'b1;
    bus.m_err_i  = 1'b1;
    bus.m_data_i = 8'h77;
    @(negedge clk_i);
    check_val("rw_in_wait", 32'(bus.m_rdy_o), 32'(1));
    rst_ni = 1'b0;
    #1;
    check_val("rw_outs", 32'({bus.req_rdy_o, bus.rsp_val_o, bus.m_val_o, bus.m_rdy_o, bus.rsp_err_o}), 32'(0));
    check_val("rw_rdata", 32'(bus.rsp_data_o), 32'(0));
    @(posedge clk_i); #1;
    bus.m_val_i  = 1'b0;
    bus.m_err_i  = 1'b0;
    bus.m_data_i = 8'h00;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    post(2, 7'h66, 8'h77, 8'h88, 1'b1);
    post(3, 7'h0C, 8'h0D, 8'h0E, 1'b1);
    post(0, 7'h01, 8'h02, 8'h03, 1'b0);
    serve(0, 7'h01, 8'h02, 8'h03, 1'b0, 0, 8'h9A, 1, 1'b0, 1'b0);
    bus.req_val_i = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_arb.md
# i2c_arb

Round-robin arbiter and retry sequencer that shares one I2C master between `N_REQ` independent requesters (sensor poller, codec config, EEPROM loader, host bridge). It sits directly in front of the I2C master's request/response handshake ports. It serialises single-register transactions, retries NACKed transfers up to `RETRIES` times, and routes each result back to the requester that issued it.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `RETRIES`, default 2: extra attempts after a NACK, 0..7.

- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_val_i`  in  N_REQ  per-requester transaction valid
- `req_daddr_i`  in  7*N_REQ  device address, slice k = bits [7k+6:7k]
- `req_addr_i`  in  8*N_REQ  register address, slice k = [8k+7:8k]
- `req_data_i`  in  8*N_REQ  write data, slice k = [8k+7:8k]
- `req_wen_i`  in  N_REQ  1 = write, 0 = read
- `req_rdy_o`  out  N_REQ  one-hot accept strobe
- `rsp_val_o`  out  N_REQ  one-hot response valid
- `rsp_err_o`  out  1  final NACK status, shared, valid with any `rsp_val_o`
- `rsp_data_o`  out  8  read data, shared, valid with any `rsp_val_o`
- `rsp_rdy_i`  in  N_REQ  per-requester response ready
- `m_val_o`  out  1  to master: request valid
- `m_daddr_o`  out  7  device address to master
- `m_addr_o`  out  8  register address to master
- `m_data_o`  out  8  write data to master
- `m_wen_o`  out  1  write enable to master
- `m_rdy_i`  in  1  master ready
- `m_val_i`  in  1  master completion valid
- `m_err_i`  in  1  master NACK flag
- `m_data_i`  in  8  master read data
- `m_rdy_o`  out  1  ready for master completion

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Scan `req_val_i` starting at index `last+1` (mod N_REQ) and select the first set bit `g`.
  - Assert `req_rdy_o[g]` combinationally in this cycle only.
  - Capture daddr/addr/data/wen of slice g into holding registers.
  - Set `grant <= g` and `retry_cnt <= 0`, then go to ISSUE.
  - With no valid request, stay in IDLE with all outputs low.
- **ISSUE**
  - `m_val_o=1` with the held fields.
  - Held fields stay stable until `m_rdy_i` is sampled high, then go to WAIT.
- **WAIT**
  - `m_rdy_o=1`.
  - On `m_val_i`, register `m_err_i` into `rsp_err_o` and `m_data_i` into `rsp_data_o`.
  - If `m_err_i=1` and `retry_cnt < RETRIES`: `retry_cnt++` and go to ISSUE. The held fields are reused, so the requester is not re-handshaked.
  - Otherwise go to RESP.
- **RESP**
  - `rsp_val_o[grant]=1`; all other bits stay 0.
  - On `rsp_rdy_i[grant]`: set `last <= grant` and go to IDLE.
  - `rsp_rdy_i` bits of non-granted requesters are ignored.
- `rsp_data_o` is meaningful only for reads. For writes it carries whatever the master returned and is don't-care to requesters.
- Requests arriving during ISSUE/WAIT/RESP are held off; `req_rdy_o` stays 0. Requesters keep `req_val_i` asserted and must not change slice fields until accepted.
- Only one transaction is outstanding at a time. The block never asserts `m_val_o` while WAIT or RESP is active.

## Timing
- Reset values:
  - State IDLE, `last = N_REQ-1` (so requester 0 wins first), `grant=0`, `retry_cnt=0`.
  - `rsp_err_o=0`, `rsp_data_o=0`, held fields 0.
  - All outputs (`req_rdy_o`, `rsp_val_o`, `m_val_o`, `m_rdy_o`, `m_*` fields) 0.
- Reset mid-transaction forces IDLE immediately. The master shares `rst_ni` and aborts too, so no stale completion is expected.
- Latency:
  - Accept at cycle T gives `m_val_o` at T+1.
  - Completion handshake at cycle C gives `rsp_val_o` at C+1.
  - Retry: `m_val_o` reasserts at C+1.
- Minimum gap between a response handshake and the next accept is 1 cycle (the IDLE cycle).
- Fairness: under continuous requests from all requesters, grants rotate 0,1,2,…,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- Single active requester: it is granted back-to-back, every transaction.
- `retry_cnt` is 3 bits and never exceeds `RETRIES`. Total master attempts per transaction = 1..RETRIES+1.
- Simultaneous `m_val_i` and reset: reset wins.

## Test plan
- **Single write.** Req 1 writes daddr 0x50, addr 0x10, data 0xA5. Expect:
  - `m_*` = 0x50/0x10/0xA5/wen=1 one cycle after accept.
  - Master ACKs; `rsp_val_o=4'b0010` with `rsp_err_o=0`.
- **Read data return.** Req 2 reads; the master returns 0x3C. Expect `rsp_data_o=0x3C` and `rsp_val_o[2]` held until `rsp_rdy_i[2]`.
- **Round-robin rotation.** All 4 requesters held valid from reset, with the master always ACKing. Expect grant order 0,1,2,3,0,1.
- **Retry then succeed.** `RETRIES=2`, and the master NACKs the first attempt then ACKs. Expect exactly 2 `m_val_o` handshakes with identical fields, then `rsp_err_o=0`.
- **Retry exhausted.** `RETRIES=2` and the master always NACKs. Expect 3 attempts, then `rsp_err_o=1`.
- **Reset in WAIT.** Assert `rst_ni=0` during WAIT. Expect all outputs 0 immediately, and after release requester 0 is granted first.
